// File: rtl/mem_bus_responder.sv
// Word-addressed RAM responder for the RD/WR/ACK four-phase bus with programmable wait states
// and an ERROR flag that qualifies ACK for out-of-range or conflicting requests.
module mem_bus_responder #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int ADDRWIDTH     = 6,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     MEM_BUS_RESPONDER_CLOCK_50,
    input  logic                     MEM_BUS_RESPONDER_RESET_InLow,
    input  logic                     MEM_BUS_RESPONDER_RD_In,
    input  logic                     MEM_BUS_RESPONDER_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_RESPONDER_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_RESPONDER_data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_BUS_RESPONDER_data_OutBUS,
    output logic                     MEM_BUS_RESPONDER_ACK_Out,
    output logic                     MEM_BUS_RESPONDER_ERROR_Out,
    output logic                     MEM_BUS_RESPONDER_BUSY_Out
);

    localparam int         DEPTH     = 2 ** ADDRWIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
    logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;

    logic [DATAWIDTH_BUS-1:0] mem [0:DEPTH-1];

    logic                     req_s;
    logic                     bad_s;
    logic                     mem_we_s;
    logic [ADDRWIDTH-1:0]     idx_s;

    // Next-state, latch and commit logic; errors are judged on the latched request only
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = ack_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        req_s    = MEM_BUS_RESPONDER_RD_In | MEM_BUS_RESPONDER_WR_In;
        idx_s    = addr_q[ADDRWIDTH-1:0];
        bad_s    = ((addr_q >> ADDRWIDTH) != '0) || (rd_q && wr_q);
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    rd_d    = MEM_BUS_RESPONDER_RD_In;
                    wr_d    = MEM_BUS_RESPONDER_WR_In;
                    addr_d  = MEM_BUS_RESPONDER_ADDRESS_InBUS;
                    wdata_d = MEM_BUS_RESPONDER_data_InBUS;
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // A dropped request wins over a commit due on the same edge
                if (!req_s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    err_d   = bad_s;
                    if (bad_s) begin
                        rdata_d = '0;
                    end else if (wr_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rdata_d = mem[idx_s];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACK;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge MEM_BUS_RESPONDER_CLOCK_50) begin
        if (!MEM_BUS_RESPONDER_RESET_InLow) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // RAM array is never cleared; a reset edge suppresses a commit due on that edge
    always_ff @(posedge MEM_BUS_RESPONDER_CLOCK_50) begin
        if (MEM_BUS_RESPONDER_RESET_InLow && mem_we_s) begin
            mem[idx_s] <= wdata_q;
        end
    end

    assign MEM_BUS_RESPONDER_data_OutBUS = rdata_q;
    assign MEM_BUS_RESPONDER_ACK_Out     = ack_q;
    assign MEM_BUS_RESPONDER_ERROR_Out   = err_q;
    assign MEM_BUS_RESPONDER_BUSY_Out    = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with two wait states, one with none.
module tb_mem_bus_responder;

    logic        clk;
    logic        rst_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        ack  [2];
    logic        err  [2];
    logic        busy [2];

    int n_checks;
    int n_errors;

    mem_bus_responder #(.DATAWIDTH_BUS(32), .ADDRWIDTH(6), .WAIT_CYCLES(2)) dut_w2 (
        .MEM_BUS_RESPONDER_CLOCK_50      (clk),
        .MEM_BUS_RESPONDER_RESET_InLow   (rst_n),
        .MEM_BUS_RESPONDER_RD_In         (rd[0]),
        .MEM_BUS_RESPONDER_WR_In         (wr[0]),
        .MEM_BUS_RESPONDER_ADDRESS_InBUS (addr[0]),
        .MEM_BUS_RESPONDER_data_InBUS    (din[0]),
        .MEM_BUS_RESPONDER_data_OutBUS   (dout[0]),
        .MEM_BUS_RESPONDER_ACK_Out       (ack[0]),
        .MEM_BUS_RESPONDER_ERROR_Out     (err[0]),
        .MEM_BUS_RESPONDER_BUSY_Out      (busy[0])
    );

    mem_bus_responder #(.DATAWIDTH_BUS(32), .ADDRWIDTH(6), .WAIT_CYCLES(0)) dut_w0 (
        .MEM_BUS_RESPONDER_CLOCK_50      (clk),
        .MEM_BUS_RESPONDER_RESET_InLow   (rst_n),
        .MEM_BUS_RESPONDER_RD_In         (rd[1]),
        .MEM_BUS_RESPONDER_WR_In         (wr[1]),
        .MEM_BUS_RESPONDER_ADDRESS_InBUS (addr[1]),
        .MEM_BUS_RESPONDER_data_InBUS    (din[1]),
        .MEM_BUS_RESPONDER_data_OutBUS   (dout[1]),
        .MEM_BUS_RESPONDER_ACK_Out       (ack[1]),
        .MEM_BUS_RESPONDER_ERROR_Out     (err[1]),
        .MEM_BUS_RESPONDER_BUSY_Out      (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full handshake: request, count edges to ACK, check, then release and check ACK falls
    task automatic xfer(input int s, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_data, input string tag);
        int  n;
        bit  got;
        @(negedge clk);
        rd[s] = r; wr[s] = w; addr[s] = a; din[s] = d;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[s] === 1'b1) got = 1'b1;
        end
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_err"}, {31'd0, err[s]}, {31'd0, exp_err});
        check_val({tag, "_data"}, dout[s], exp_data);
        check_val({tag, "_busy"}, {31'd0, busy[s]}, 32'd1);
        // Address/data wander while ACK is held; must be ignored
        @(negedge clk);
        addr[s] = 32'hFFFF_FFFF; din[s] = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        check_val({tag, "_ackhold"}, {31'd0, ack[s]}, 32'd1);
        @(negedge clk);
        rd[s] = 1'b0; wr[s] = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_ackfall"}, {31'd0, ack[s]}, 32'd0);
        check_val({tag, "_errfall"}, {31'd0, err[s]}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, busy[s]}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; din[i] = 32'd0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("rst_ack", {31'd0, ack[i]}, 32'd0);
            check_val("rst_err", {31'd0, err[i]}, 32'd0);
            check_val("rst_busy", {31'd0, busy[i]}, 32'd0);
            check_val("rst_dout", dout[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back with two wait states; writes leave data_OutBUS alone
        xfer(0, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 4, 1'b0, 32'd0, "wr5");
        xfer(0, 1'b1, 1'b0, 32'd5, 32'h0, 4, 1'b0, 32'hDEAD_BEEF, "rd5");
        xfer(0, 1'b0, 1'b1, 32'd0, 32'h1234_5678, 4, 1'b0, 32'hDEAD_BEEF, "wr0");

        // Out of range then a good read
        xfer(0, 1'b1, 1'b0, 32'h40, 32'h0, 4, 1'b1, 32'd0, "rd_oor");
        xfer(0, 1'b1, 1'b0, 32'd0, 32'h0, 4, 1'b0, 32'h1234_5678, "rd0");

        // Illegal RD+WR leaves RAM untouched
        xfer(0, 1'b0, 1'b1, 32'd3, 32'h0000_00A5, 4, 1'b0, 32'h1234_5678, "wr3");
        xfer(0, 1'b1, 1'b1, 32'd3, 32'h0000_00FF, 4, 1'b1, 32'd0, "rdwr3");
        xfer(0, 1'b1, 1'b0, 32'd3, 32'h0, 4, 1'b0, 32'h0000_00A5, "rd3");

        // Abort after one edge in WAIT
        xfer(0, 1'b0, 1'b1, 32'd7, 32'h0000_0011, 4, 1'b0, 32'h0000_00A5, "wr7");
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'd7; din[0] = 32'h0000_0055;
        @(posedge clk); #1;
        check_val("abort_busy", {31'd0, busy[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        wr[0] = 1'b0;
        @(posedge clk); #1;
        check_val("abort_ack", {31'd0, ack[0]}, 32'd0);
        check_val("abort_busy0", {31'd0, busy[0]}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("abort_noack", {31'd0, ack[0]}, 32'd0);
        xfer(0, 1'b1, 1'b0, 32'd7, 32'h0, 4, 1'b0, 32'h0000_0011, "rd7");

        // Reset during WAIT drops the pending write
        xfer(0, 1'b0, 1'b1, 32'd10, 32'h0000_0020, 4, 1'b0, 32'h0000_0011, "wr10");
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'd10; din[0] = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("midrst_ack", {31'd0, ack[0]}, 32'd0);
        check_val("midrst_busy", {31'd0, busy[0]}, 32'd0);
        check_val("midrst_dout", dout[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1; wr[0] = 1'b0;
        xfer(0, 1'b1, 1'b0, 32'd10, 32'h0, 4, 1'b0, 32'h0000_0020, "rd10");

        // Zero wait states
        xfer(1, 1'b0, 1'b1, 32'd63, 32'h0000_0001, 2, 1'b0, 32'd0, "z_wr63");
        xfer(1, 1'b1, 1'b0, 32'd63, 32'h0, 2, 1'b0, 32'h0000_0001, "z_rd63");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
